// File: rtl/keccak_dom_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keccak_dom_pkg
// Description : Shared LFSR geometry, Z-width function and FSM encoding for
//               the masked chi fresh-randomness producer.
// Revision    : 1.0
// ============================================================================
package keccak_dom_pkg;

    localparam int unsigned C_LFSR_W = 63;
    localparam int unsigned C_TAP_HI = 62;
    localparam int unsigned C_TAP_LO = 61;

    typedef enum logic [1:0] {
        ST_NOSEED = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } rng_state_e;

    // One bit per pairwise share product, five lanes per chi row
    function automatic int unsigned z_width(input int unsigned shares);
        return ((shares * shares - shares) / 2) * 5;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keccak_lfsr_step.sv
`default_nettype none
// ============================================================================
// Module      : keccak_lfsr_step
// Description : N unrolled Fibonacci LFSR steps; bit k is the feedback of step k.
// Revision    : 1.0
// ============================================================================
module keccak_lfsr_step
    import keccak_dom_pkg::*;
#(
    parameter int unsigned N = 15
) (
    input  logic [C_LFSR_W-1:0] i_state,
    output logic [C_LFSR_W-1:0] o_state,
    output logic [N-1:0]        o_bits
);

    logic [C_LFSR_W-1:0] w_state;
    logic                w_fb;

    always_comb begin
        w_state = i_state;
        w_fb    = 1'b0;
        o_bits  = '0;
        for (int k = 0; k < int'(N); k++) begin
            w_fb      = w_state[C_TAP_HI] ^ w_state[C_TAP_LO];
            o_bits[k] = w_fb;
            w_state   = {w_state[C_LFSR_W-2:0], w_fb};
        end
        o_state = w_state;
    end

endmodule
`default_nettype wire

// File: rtl/keccak_dom_rng.sv
`default_nettype none
// ============================================================================
// Module      : keccak_dom_rng
// Description : Seeded LFSR producer of fresh Z randomness for a masked chi.
// Revision    : 1.0
// ============================================================================
module keccak_dom_rng
    import keccak_dom_pkg::*;
#(
    parameter  int unsigned SHARES        = 3,
    parameter  int unsigned WARMUP_CYCLES = 5,
    localparam int unsigned N             = z_width(SHARES)
) (
    input  logic                ClkxCI,
    input  logic                RstxRBI,
    input  logic [C_LFSR_W-1:0] SeedxDI,
    input  logic                SeedValidxSI,
    output logic                SeedReadyxSO,
    input  logic                EnxSI,
    output logic [N-1:0]        ZxDO,
    output logic                ZValidxSO
);

    localparam logic [7:0]          C_WARM_LAST = 8'(WARMUP_CYCLES);
    localparam logic [C_LFSR_W-1:0] C_SEED_ONE  = {{(C_LFSR_W-1){1'b0}}, 1'b1};

    rng_state_e          r_state_q, w_state_d;
    logic [C_LFSR_W-1:0] r_lfsr_q, w_lfsr_d, w_lfsr_adv;
    logic [N-1:0]        r_z_q, w_z_d, w_bits;
    logic [7:0]          r_cnt_q, w_cnt_d, w_cnt_inc;
    logic                w_seed_take;

    keccak_lfsr_step #(
        .N (N)
    ) u_step (
        .i_state (r_lfsr_q),
        .o_state (w_lfsr_adv),
        .o_bits  (w_bits)
    );

    assign SeedReadyxSO = (r_state_q != ST_WARMUP);
    assign ZValidxSO    = (r_state_q == ST_RUN);
    assign ZxDO         = r_z_q & {N{ZValidxSO}};
    assign w_seed_take  = SeedValidxSI & SeedReadyxSO;
    assign w_cnt_inc    = r_cnt_q + 8'd1;

    always_comb begin
        w_state_d = r_state_q;
        w_lfsr_d  = r_lfsr_q;
        w_z_d     = r_z_q;
        w_cnt_d   = r_cnt_q;
        case (r_state_q)
            ST_NOSEED: ;
            ST_WARMUP: begin
                w_lfsr_d = w_lfsr_adv;
                w_cnt_d  = w_cnt_inc;
                if (w_cnt_inc == C_WARM_LAST) begin
                    w_state_d = ST_RUN;
                    w_z_d     = w_bits;
                end
            end
            ST_RUN: begin
                if (EnxSI) begin
                    w_lfsr_d = w_lfsr_adv;
                    w_z_d    = w_bits;
                end
            end
            default: w_state_d = ST_NOSEED;
        endcase
        // A new seed overrides any advance requested in the same cycle
        if (w_seed_take) begin
            w_lfsr_d  = (SeedxDI == '0) ? C_SEED_ONE : SeedxDI;
            w_cnt_d   = 8'd0;
            w_state_d = ST_WARMUP;
        end
    end

    always_ff @(posedge ClkxCI or negedge RstxRBI) begin
        if (!RstxRBI) begin
            r_state_q <= ST_NOSEED;
            r_lfsr_q  <= '0;
            r_z_q     <= '0;
            r_cnt_q   <= 8'd0;
        end else begin
            r_state_q <= w_state_d;
            r_lfsr_q  <= w_lfsr_d;
            r_z_q     <= w_z_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keccak_dom_rng.sv
`default_nettype none
// ============================================================================
// Module      : tb_keccak_dom_rng
// Description : Scoreboard bench for keccak_dom_rng with a bit-history model.
// Revision    : 1.0
// ============================================================================
module tb_keccak_dom_rng;

    logic        clk;
    logic        rst_n;
    logic [62:0] seed;
    logic        seed_valid;
    logic        seed_ready;
    logic        en;
    logic [14:0] z;
    logic        z_valid;

    int n_checks = 0;
    int n_errors = 0;

    logic [14:0] sb[$];
    bit          hist[$];

    keccak_dom_rng #(
        .SHARES        (3),
        .WARMUP_CYCLES (5)
    ) dut (
        .ClkxCI       (clk),
        .RstxRBI      (rst_n),
        .SeedxDI      (seed),
        .SeedValidxSI (seed_valid),
        .SeedReadyxSO (seed_ready),
        .EnxSI        (en),
        .ZxDO         (z),
        .ZValidxSO    (z_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sequence model: x[t] = x[t-63] ^ x[t-62]; hist holds the last 63 bits, oldest first
    task automatic model_seed(input logic [62:0] s);
        logic [62:0] v;
        v = (s == '0) ? 63'h1 : s;
        hist.delete();
        for (int i = 62; i >= 0; i--) hist.push_back(v[i]);
    endtask

    task automatic model_word(output logic [14:0] w);
        bit f;
        for (int k = 0; k < 15; k++) begin
            f    = hist[0] ^ hist[1];
            w[k] = f;
            hist.push_back(f);
            void'(hist.pop_front());
        end
    endtask

    // Called just after a negedge; handshake edge is the following posedge
    task automatic seed_load(input logic [62:0] s, input bit en_too, input bit chk);
        logic [14:0] w;
        seed       = s;
        seed_valid = 1'b1;
        en         = en_too;
        model_seed(s);
        for (int i = 0; i < 5; i++) model_word(w);
        sb.push_back(w);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            seed       = {$urandom, $urandom};
            seed_valid = 1'($urandom);
            en         = 1'($urandom);
            if (chk) begin
                check("warmup_valid_low", z_valid, 0);
                check("warmup_ready_low", seed_ready, 0);
            end
        end
        @(negedge clk); #1;
        seed_valid = 1'b0;
        en         = 1'b0;
        if (chk) begin
            check("run_valid_high", z_valid, 1);
            check("run_ready_high", seed_ready, 1);
        end
    endtask

    task automatic consume_one();
        logic [14:0] w;
        model_word(w);
        sb.push_back(w);
        en = 1'b1;
        @(negedge clk); #1;
        en = 1'b0;
    endtask

    // Monitor: retire the word consumed at the last edge, then check the presented one
    initial begin
        bit pv, pr;
        pv = 1'b0;
        pr = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 1'b0;
                pr = 1'b1;
            end else begin
                if (pv && (en || (seed_valid && pr)) && sb.size() > 0)
                    void'(sb.pop_front());
                if (z_valid) begin
                    n_checks++;
                    if (sb.size() == 0) begin
                        n_errors++;
                        $display("FAIL sb_word: got %0h expected none queued at %0t", z, $time);
                    end else if (z !== sb[0]) begin
                        n_errors++;
                        $display("FAIL sb_word: got %0h expected %0h at %0t", z, sb[0], $time);
                    end
                end else begin
                    check("z_zero_when_invalid", z, 0);
                end
                pv = z_valid;
                pr = seed_ready;
            end
        end
    end

    initial begin
        #2_000_000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        int consumed;
        int r;
        rst_n      = 1'b0;
        seed       = '0;
        seed_valid = 1'b0;
        en         = 1'b0;
        #12;
        check("reset_z", z, 0);
        check("reset_valid", z_valid, 0);
        check("reset_ready", seed_ready, 1);
        @(negedge clk); #1;
        rst_n = 1'b1;

        // NOSEED ignores enable
        en = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("noseed_valid", z_valid, 0);
        check("noseed_ready", seed_ready, 1);
        en = 1'b0;

        seed_load(63'h1, 1'b0, 1'b1);
        check("seed1_first_word", z, 15'h0006);
        consume_one();
        check("seed1_second_word", z, 15'h0000);
        check("seed1_valid_kept", z_valid, 1);

        seed_load(63'h0, 1'b0, 1'b1);
        check("seed0_first_word", z, 15'h0006);

        // Idle hold, then consume: scoreboard verifies no skipped advance
        repeat (10) @(negedge clk);
        #1;
        consume_one();
        consume_one();

        // Seed in RUN wins over simultaneous enable
        seed_load(63'h1, 1'b1, 1'b1);
        check("reseed_word", z, 15'h0006);

        // Reset in the middle of warmup
        seed       = 63'h5A5A_1234_0F0F_CAFE;
        seed_valid = 1'b1;
        @(negedge clk); #1;
        seed_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midwarm_rst_z", z, 0);
        check("midwarm_rst_valid", z_valid, 0);
        check("midwarm_rst_ready", seed_ready, 1);
        sb.delete();
        @(negedge clk); #1;
        rst_n = 1'b1;
        en    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            check("post_rst_no_valid", z_valid, 0);
        end
        en = 1'b0;

        // Randomised stream with occasional reseeds
        seed_load({$urandom, $urandom}, 1'b0, 1'b1);
        consumed = 0;
        while (consumed < 1000) begin
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                seed_load((r == 0) ? 63'h0 : {$urandom, $urandom}, 1'($urandom), 1'b1);
            end else if (r < 70) begin
                consume_one();
                consumed++;
            end else begin
                @(negedge clk); #1;
            end
        end
        repeat (3) @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
